// File: rtl/dlx_pkg.sv
// Shared DLX decode definitions: opcodes, R-type functions, ALU operations and control bundle.
package dlx_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQZ  = 6'h04;
    localparam logic [5:0] OP_BNEZ  = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDUI = 6'h09;
    localparam logic [5:0] OP_SUBI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LHI   = 6'h0F;
    localparam logic [5:0] OP_JR    = 6'h12;
    localparam logic [5:0] OP_JALR  = 6'h13;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [10:0] FN_SLL = 11'h004;
    localparam logic [10:0] FN_SRL = 11'h006;
    localparam logic [10:0] FN_SRA = 11'h007;
    localparam logic [10:0] FN_ADD = 11'h020;
    localparam logic [10:0] FN_SUB = 11'h022;
    localparam logic [10:0] FN_AND = 11'h024;
    localparam logic [10:0] FN_OR  = 11'h025;
    localparam logic [10:0] FN_XOR = 11'h026;
    localparam logic [10:0] FN_SLT = 11'h02A;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7,
        ALU_SLT = 4'd8,
        ALU_LHI = 4'd9
    } alu_op_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    reg_we;
        logic    mem_rd;
        logic    mem_wr;
        logic    use_imm;
        logic    branch;
        logic    branch_nz;
        logic    jump;
        logic    jump_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = ctrl_t'('0);

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/dlx_decoder.sv
// Combinational DLX instruction decoder: register numbers, immediate and control bits.
module dlx_decoder
    import dlx_pkg::*;
(
    input  logic [31:0] instr,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic [31:0] imm,
    output ctrl_t       ctrl,
    output logic        illegal
);

    logic [5:0]  opcode;
    logic [10:0] func;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rt;
    logic [4:0]  f_rd;
    logic [15:0] imm16;

    assign opcode = instr[31:26];
    assign func   = instr[10:0];
    assign f_rs1  = instr[25:21];
    assign f_rt   = instr[20:16];
    assign f_rd   = instr[15:11];
    assign imm16  = instr[15:0];

    // Decode by opcode; unknown encodings leave every output zero except illegal.
    always_comb begin
        rs1      = 5'd0;
        rs2      = 5'd0;
        rd       = 5'd0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        imm      = 32'd0;
        ctrl     = CTRL_NONE;
        illegal  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rs1         = f_rs1;
                rs2         = f_rt;
                rd          = f_rd;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                ctrl.reg_we = 1'b1;
                case (func)
                    FN_SLL:  ctrl.alu_op = ALU_SLL;
                    FN_SRL:  ctrl.alu_op = ALU_SRL;
                    FN_SRA:  ctrl.alu_op = ALU_SRA;
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_SLT:  ctrl.alu_op = ALU_SLT;
                    default: begin
                        rs1      = 5'd0;
                        rs2      = 5'd0;
                        rd       = 5'd0;
                        uses_rs1 = 1'b0;
                        uses_rs2 = 1'b0;
                        ctrl     = CTRL_NONE;
                        illegal  = 1'b1;
                    end
                endcase
            end
            OP_J, OP_JAL: begin
                imm       = {{6{instr[25]}}, instr[25:0]};
                ctrl.jump = 1'b1;
                if (opcode == OP_JAL) begin
                    rd          = 5'd31;
                    ctrl.reg_we = 1'b1;
                end
            end
            OP_BEQZ, OP_BNEZ: begin
                rs1            = f_rs1;
                uses_rs1       = 1'b1;
                imm            = sext16(imm16);
                ctrl.branch    = 1'b1;
                ctrl.branch_nz = (opcode == OP_BNEZ);
            end
            OP_ADDI, OP_ADDUI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI: begin
                rs1          = f_rs1;
                rd           = f_rt;
                uses_rs1     = 1'b1;
                ctrl.reg_we  = 1'b1;
                ctrl.use_imm = 1'b1;
                imm          = {16'd0, imm16};
                case (opcode)
                    OP_ADDI: begin
                        imm         = sext16(imm16);
                        ctrl.alu_op = ALU_ADD;
                    end
                    OP_SUBI: begin
                        imm         = sext16(imm16);
                        ctrl.alu_op = ALU_SUB;
                    end
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_XORI: ctrl.alu_op = ALU_XOR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            OP_LHI: begin
                rd           = f_rt;
                imm          = {imm16, 16'd0};
                ctrl.alu_op  = ALU_LHI;
                ctrl.reg_we  = 1'b1;
                ctrl.use_imm = 1'b1;
            end
            OP_JR, OP_JALR: begin
                rs1           = f_rs1;
                uses_rs1      = 1'b1;
                ctrl.jump_reg = 1'b1;
                if (opcode == OP_JALR) begin
                    rd          = 5'd31;
                    ctrl.reg_we = 1'b1;
                end
            end
            OP_LW: begin
                rs1          = f_rs1;
                rd           = f_rt;
                uses_rs1     = 1'b1;
                imm          = sext16(imm16);
                ctrl.reg_we  = 1'b1;
                ctrl.mem_rd  = 1'b1;
                ctrl.use_imm = 1'b1;
            end
            OP_SW: begin
                rs1          = f_rs1;
                rs2          = f_rt;
                uses_rs1     = 1'b1;
                uses_rs2     = 1'b1;
                imm          = sext16(imm16);
                ctrl.mem_wr  = 1'b1;
                ctrl.use_imm = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // r0 writes are dropped so the word behaves as a true NOP downstream.
        if (rd == 5'd0) begin
            ctrl.reg_we = 1'b0;
        end
    end

endmodule

// File: rtl/dlx_id_stage.sv
// DLX decode stage: valid/ready handshake, load-use bubble insertion and output register.
module dlx_id_stage
    import dlx_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        flush,
    input  logic        ex_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [4:0]  Rs1,
    output logic [4:0]  Rs2,
    output logic [4:0]  Rd,
    output logic [31:0] imm,
    output alu_op_t     alu_op,
    output logic        reg_we,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        use_imm,
    output logic        branch,
    output logic        branch_nz,
    output logic        jump,
    output logic        jump_reg,
    output logic        illegal
);

    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic [4:0]  dec_rd;
    logic        dec_uses_rs1;
    logic        dec_uses_rs2;
    logic [31:0] dec_imm;
    ctrl_t       dec_ctrl;
    logic        dec_illegal;
    ctrl_t       ctrl_q;
    logic        adv;
    logic        hazard;
    logic        transfer;

    dlx_decoder u_decoder (
        .instr    (if_instr),
        .rs1      (dec_rs1),
        .rs2      (dec_rs2),
        .rd       (dec_rd),
        .uses_rs1 (dec_uses_rs1),
        .uses_rs2 (dec_uses_rs2),
        .imm      (dec_imm),
        .ctrl     (dec_ctrl),
        .illegal  (dec_illegal)
    );

    // Handshake and load-use check against the held load's destination.
    always_comb begin
        adv      = !id_valid || ex_ready;
        hazard   = id_valid && ctrl_q.mem_rd && (Rd != 5'd0) && if_valid &&
                   ((dec_uses_rs1 && (dec_rs1 == Rd)) || (dec_uses_rs2 && (dec_rs2 == Rd)));
        if_ready = adv && !hazard && !flush;
        transfer = if_valid && if_ready;
    end

    // Output register: flush kills, transfer loads, an empty advance makes a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_valid <= 1'b0;
            id_pc    <= 32'd0;
            Rs1      <= 5'd0;
            Rs2      <= 5'd0;
            Rd       <= 5'd0;
            imm      <= 32'd0;
            ctrl_q   <= CTRL_NONE;
            illegal  <= 1'b0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (transfer) begin
            id_valid <= 1'b1;
            id_pc    <= if_pc;
            Rs1      <= dec_rs1;
            Rs2      <= dec_rs2;
            Rd       <= dec_rd;
            imm      <= dec_imm;
            ctrl_q   <= dec_ctrl;
            illegal  <= dec_illegal;
        end else if (adv) begin
            id_valid <= 1'b0;
        end
    end

    assign alu_op    = ctrl_q.alu_op;
    assign reg_we    = ctrl_q.reg_we;
    assign mem_rd    = ctrl_q.mem_rd;
    assign mem_wr    = ctrl_q.mem_wr;
    assign use_imm   = ctrl_q.use_imm;
    assign branch    = ctrl_q.branch;
    assign branch_nz = ctrl_q.branch_nz;
    assign jump      = ctrl_q.jump;
    assign jump_reg  = ctrl_q.jump_reg;

endmodule
